id_stage: RTL and testbench

//  Instruction-decode stage that sits directly upstream of the register file.

---
 rtl/id_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: decodes one MIPS-style instruction per cycle, drives the regfile
// read ports, forwards EX/MEM results, detects load-use hazards and registers the ID/EX bundle.
module id_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_valid,
    input  logic [DW-1:0]  if_inst,
    input  logic [DW-1:0]  if_pc,
    output logic           id_ready,
    output logic           reg1_re,
    output logic [AW-1:0]  reg1_addr,
    input  logic [DW-1:0]  reg1_data,
    output logic           reg2_re,
    output logic [AW-1:0]  reg2_addr,
    input  logic [DW-1:0]  reg2_data,
    input  logic           fwd_ex_we,
    input  logic [AW-1:0]  fwd_ex_waddr,
    input  logic [DW-1:0]  fwd_ex_wdata,
    input  logic           fwd_ex_load,
    input  logic           fwd_mem_we,
    input  logic [AW-1:0]  fwd_mem_waddr,
    input  logic [DW-1:0]  fwd_mem_wdata,
    input  logic           ex_stall,
    input  logic           flush,
    output logic           idex_valid,
    output logic [DW-1:0]  idex_pc,
    output logic [OPW-1:0] idex_aluop,
    output logic [DW-1:0]  idex_opnd1,
    output logic [DW-1:0]  idex_opnd2,
    output logic [DW-1:0]  idex_sdata,
    output logic           idex_wreg,
    output logic [AW-1:0]  idex_waddr,
    output logic           idex_inv
);

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_AND  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_ADDU = 4'd4,
        ALU_SUBU = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_LW   = 4'd10,
        ALU_SW   = 4'd11
    } aluop_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [AW-1:0] rd;

    assign opcode    = if_inst[31:26];
    assign funct     = if_inst[5:0];
    assign shamt     = if_inst[10:6];
    assign imm       = if_inst[15:0];
    assign rd        = if_inst[11+AW-1:11];
    assign reg1_addr = if_inst[21+AW-1:21];
    assign reg2_addr = if_inst[16+AW-1:16];

    aluop_e        dec_aluop;
    logic          dec_use1;
    logic          dec_use2;
    logic          dec_shift;
    logic          dec_use_imm;
    logic [DW-1:0] dec_imm;
    logic [AW-1:0] dec_waddr;
    logic          dec_wreg;
    logic          dec_store;
    logic          dec_inv;

    always_comb begin
        dec_aluop   = ALU_NOP;
        dec_use1    = 1'b0;
        dec_use2    = 1'b0;
        dec_shift   = 1'b0;
        dec_use_imm = 1'b0;
        dec_imm     = '0;
        dec_waddr   = '0;
        dec_wreg    = 1'b0;
        dec_store   = 1'b0;
        dec_inv     = 1'b0;
        if (opcode == 6'h00) begin
            dec_use1  = 1'b1;
            dec_use2  = 1'b1;
            dec_waddr = rd;
            dec_wreg  = 1'b1;
            case (funct)
                6'h25: dec_aluop = ALU_OR;
                6'h24: dec_aluop = ALU_AND;
                6'h26: dec_aluop = ALU_XOR;
                6'h21: dec_aluop = ALU_ADDU;
                6'h23: dec_aluop = ALU_SUBU;
                6'h2A: dec_aluop = ALU_SLT;
                6'h00, 6'h02: begin
                    dec_aluop   = (funct == 6'h00) ? ALU_SLL : ALU_SRL;
                    dec_use1    = 1'b0;
                    dec_shift   = 1'b1;
                    dec_use_imm = 1'b1;
                    dec_imm     = {{(DW-5){1'b0}}, shamt};
                end
                default: begin
                    dec_inv   = 1'b1;
                    dec_use1  = 1'b0;
                    dec_use2  = 1'b0;
                    dec_waddr = '0;
                    dec_wreg  = 1'b0;
                end
            endcase
        end else begin
            dec_use1    = 1'b1;
            dec_use_imm = 1'b1;
            dec_waddr   = reg2_addr;
            dec_wreg    = 1'b1;
            case (opcode)
                6'h0D: begin dec_aluop = ALU_OR;   dec_imm = {{(DW-16){1'b0}}, imm}; end
                6'h0C: begin dec_aluop = ALU_AND;  dec_imm = {{(DW-16){1'b0}}, imm}; end
                6'h0E: begin dec_aluop = ALU_XOR;  dec_imm = {{(DW-16){1'b0}}, imm}; end
                6'h09: begin dec_aluop = ALU_ADDU; dec_imm = {{(DW-16){imm[15]}}, imm}; end
                6'h0F: begin dec_aluop = ALU_LUI;  dec_imm = {imm, {(DW-16){1'b0}}}; end
                6'h23: begin dec_aluop = ALU_LW;   dec_imm = {{(DW-16){imm[15]}}, imm}; end
                6'h2B: begin
                    dec_aluop = ALU_SW;
                    dec_imm   = {{(DW-16){imm[15]}}, imm};
                    dec_use2  = 1'b1;
                    dec_store = 1'b1;
                    dec_wreg  = 1'b0;
                end
                default: begin
                    dec_inv     = 1'b1;
                    dec_use1    = 1'b0;
                    dec_use_imm = 1'b0;
                    dec_waddr   = '0;
                    dec_wreg    = 1'b0;
                end
            endcase
        end
    end

    assign reg1_re = if_valid & dec_use1;
    assign reg2_re = if_valid & dec_use2;

    function automatic logic [DW-1:0] fwd_sel(input logic re, input logic [AW-1:0] addr,
                                              input logic [DW-1:0] rf_data);
        if (!re || addr == '0)                        return '0;
        else if (fwd_ex_we && fwd_ex_waddr == addr)   return fwd_ex_wdata;
        else if (fwd_mem_we && fwd_mem_waddr == addr) return fwd_mem_wdata;
        else                                          return rf_data;
    endfunction

    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic          hazard;

    assign src1 = fwd_sel(reg1_re, reg1_addr, reg1_data);
    assign src2 = fwd_sel(reg2_re, reg2_addr, reg2_data);

    // EX holds a load whose data is not available yet; only enabled ports count
    assign hazard = fwd_ex_load & fwd_ex_we & (fwd_ex_waddr != '0) &
                    ((reg1_re & (reg1_addr == fwd_ex_waddr)) |
                     (reg2_re & (reg2_addr == fwd_ex_waddr)));

    assign id_ready = rst & ((if_valid & ~hazard & ~ex_stall) | flush);

    logic          idex_valid_q, idex_valid_d;
    logic [DW-1:0] idex_pc_q,    idex_pc_d;
    aluop_e        idex_aluop_q, idex_aluop_d;
    logic [DW-1:0] idex_opnd1_q, idex_opnd1_d;
    logic [DW-1:0] idex_opnd2_q, idex_opnd2_d;
    logic [DW-1:0] idex_sdata_q, idex_sdata_d;
    logic          idex_wreg_q,  idex_wreg_d;
    logic [AW-1:0] idex_waddr_q, idex_waddr_d;
    logic          idex_inv_q,   idex_inv_d;

    always_comb begin
        idex_valid_d = 1'b0;
        idex_pc_d    = '0;
        idex_aluop_d = ALU_NOP;
        idex_opnd1_d = '0;
        idex_opnd2_d = '0;
        idex_sdata_d = '0;
        idex_wreg_d  = 1'b0;
        idex_waddr_d = '0;
        idex_inv_d   = 1'b0;
        if (flush) begin
            idex_valid_d = 1'b0;
        end else if (ex_stall) begin
            idex_valid_d = idex_valid_q;
            idex_pc_d    = idex_pc_q;
            idex_aluop_d = idex_aluop_q;
            idex_opnd1_d = idex_opnd1_q;
            idex_opnd2_d = idex_opnd2_q;
            idex_sdata_d = idex_sdata_q;
            idex_wreg_d  = idex_wreg_q;
            idex_waddr_d = idex_waddr_q;
            idex_inv_d   = idex_inv_q;
        end else if (if_valid && !hazard) begin
            idex_valid_d = 1'b1;
            idex_pc_d    = if_pc;
            idex_aluop_d = dec_aluop;
            idex_opnd1_d = dec_shift ? src2 : src1;
            idex_opnd2_d = dec_use_imm ? dec_imm : src2;
            idex_sdata_d = dec_store ? src2 : '0;
            idex_wreg_d  = dec_wreg & (dec_waddr != '0);
            idex_waddr_d = dec_waddr;
            idex_inv_d   = dec_inv;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_valid_q <= 1'b0;
            idex_pc_q    <= '0;
            idex_aluop_q <= ALU_NOP;
            idex_opnd1_q <= '0;
            idex_opnd2_q <= '0;
            idex_sdata_q <= '0;
            idex_wreg_q  <= 1'b0;
            idex_waddr_q <= '0;
            idex_inv_q   <= 1'b0;
        end else begin
            idex_valid_q <= idex_valid_d;
            idex_pc_q    <= idex_pc_d;
            idex_aluop_q <= idex_aluop_d;
            idex_opnd1_q <= idex_opnd1_d;
            idex_opnd2_q <= idex_opnd2_d;
            idex_sdata_q <= idex_sdata_d;
            idex_wreg_q  <= idex_wreg_d;
            idex_waddr_q <= idex_waddr_d;
            idex_inv_q   <= idex_inv_d;
        end
    end

    assign idex_valid = idex_valid_q;
    assign idex_pc    = idex_pc_q;
    assign idex_aluop = OPW'(idex_aluop_q);
    assign idex_opnd1 = idex_opnd1_q;
    assign idex_opnd2 = idex_opnd2_q;
    assign idex_sdata = idex_sdata_q;
    assign idex_wreg  = idex_wreg_q;
    assign idex_waddr = idex_waddr_q;
    assign idex_inv   = idex_inv_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, forwarding, load-use bubble, stall, flush and reset.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        reg1_re;
    logic [4:0]  reg1_addr;
    logic [31:0] reg1_data;
    logic        reg2_re;
    logic [4:0]  reg2_addr;
    logic [31:0] reg2_data;
    logic        fwd_ex_we;
    logic [4:0]  fwd_ex_waddr;
    logic [31:0] fwd_ex_wdata;
    logic        fwd_ex_load;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_waddr;
    logic [31:0] fwd_mem_wdata;
    logic        ex_stall;
    logic        flush;
    logic        idex_valid;
    logic [31:0] idex_pc;
    logic [3:0]  idex_aluop;
    logic [31:0] idex_opnd1;
    logic [31:0] idex_opnd2;
    logic [31:0] idex_sdata;
    logic        idex_wreg;
    logic [4:0]  idex_waddr;
    logic        idex_inv;

    int checks;
    int failures;

    id_stage #(.DW(32), .AW(5), .OPW(4)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready),
        .reg1_re(reg1_re), .reg1_addr(reg1_addr), .reg1_data(reg1_data),
        .reg2_re(reg2_re), .reg2_addr(reg2_addr), .reg2_data(reg2_data),
        .fwd_ex_we(fwd_ex_we), .fwd_ex_waddr(fwd_ex_waddr), .fwd_ex_wdata(fwd_ex_wdata),
        .fwd_ex_load(fwd_ex_load),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_waddr(fwd_mem_waddr), .fwd_mem_wdata(fwd_mem_wdata),
        .ex_stall(ex_stall), .flush(flush),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_aluop(idex_aluop),
        .idex_opnd1(idex_opnd1), .idex_opnd2(idex_opnd2), .idex_sdata(idex_sdata),
        .idex_wreg(idex_wreg), .idex_waddr(idex_waddr), .idex_inv(idex_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    task automatic idle();
        if_valid      = 1'b0;
        if_inst       = '0;
        if_pc         = '0;
        reg1_data     = '0;
        reg2_data     = '0;
        fwd_ex_we     = 1'b0;
        fwd_ex_waddr  = '0;
        fwd_ex_wdata  = '0;
        fwd_ex_load   = 1'b0;
        fwd_mem_we    = 1'b0;
        fwd_mem_waddr = '0;
        fwd_mem_wdata = '0;
        ex_stall      = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        @(negedge clk);
        idle();
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        if_valid = 1'b1;
        if_inst  = itype(6'h0D, 5'd0, 5'd1, 16'h8001);
        @(posedge clk); #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", id_ready); end
        checks++; if (idex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", idex_valid); end
        checks++; if (idex_opnd2 !== 32'h0) begin failures++; $display("FAIL reset_opnd2 got=%0h exp=0", idex_opnd2); end
        checks++; if (idex_wreg !== 1'b0) begin failures++; $display("FAIL reset_wreg got=%0h exp=0", idex_wreg); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ori();
        issue(itype(6'h0D, 5'd0, 5'd1, 16'h8001), 32'h100);
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL ori_ready got=%0h exp=1", id_ready); end
        checks++; if ({reg1_re, reg2_re} !== 2'b10) begin failures++; $display("FAIL ori_re got=%0b exp=10", {reg1_re, reg2_re}); end
        checks++; if (reg2_addr !== 5'd1) begin failures++; $display("FAIL ori_reg2_addr got=%0h exp=1", reg2_addr); end
        @(posedge clk); #1;
        checks++; if (idex_valid !== 1'b1) begin failures++; $display("FAIL ori_valid got=%0h exp=1", idex_valid); end
        checks++; if (idex_aluop !== 4'd1) begin failures++; $display("FAIL ori_aluop got=%0h exp=1", idex_aluop); end
        checks++; if (idex_opnd1 !== 32'h0) begin failures++; $display("FAIL ori_opnd1 got=%0h exp=0", idex_opnd1); end
        checks++; if (idex_opnd2 !== 32'h00008001) begin failures++; $display("FAIL ori_opnd2 got=%0h exp=8001", idex_opnd2); end
        checks++; if (idex_waddr !== 5'd1 || idex_wreg !== 1'b1) begin failures++; $display("FAIL ori_dest got=%0h/%0h exp=1/1", idex_waddr, idex_wreg); end
        checks++; if (idex_pc !== 32'h100) begin failures++; $display("FAIL ori_pc got=%0h exp=100", idex_pc); end
        // ORI $0 must not write
        issue(itype(6'h0D, 5'd1, 5'd0, 16'h0005), 32'h104);
        @(posedge clk); #1;
        checks++; if (idex_wreg !== 1'b0) begin failures++; $display("FAIL ori_r0_wreg got=%0h exp=0", idex_wreg); end
    endtask

    task automatic test_forwarding();
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h110);
        fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd1; fwd_ex_wdata = 32'd5;
        fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd2; fwd_mem_wdata = 32'd7;
        @(posedge clk); #1;
        checks++; if (idex_opnd1 !== 32'd5) begin failures++; $display("FAIL fwd_ex_opnd1 got=%0h exp=5", idex_opnd1); end
        checks++; if (idex_opnd2 !== 32'd7) begin failures++; $display("FAIL fwd_mem_opnd2 got=%0h exp=7", idex_opnd2); end
        checks++; if (idex_aluop !== 4'd4 || idex_waddr !== 5'd3) begin failures++; $display("FAIL addu_dec got=%0h/%0h exp=4/3", idex_aluop, idex_waddr); end
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h114);
        fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd1; fwd_ex_wdata = 32'd5;
        fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd1; fwd_mem_wdata = 32'd9;
        reg2_data = 32'd7;
        @(posedge clk); #1;
        checks++; if (idex_opnd1 !== 32'd5) begin failures++; $display("FAIL ex_beats_mem got=%0h exp=5", idex_opnd1); end
        checks++; if (idex_opnd2 !== 32'd7) begin failures++; $display("FAIL regfile_opnd2 got=%0h exp=7", idex_opnd2); end
        issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 32'h118);
        fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd1; fwd_mem_wdata = 32'd9;
        reg1_data = 32'h11; reg2_data = 32'h22;
        @(posedge clk); #1;
        checks++; if (idex_opnd1 !== 32'd9) begin failures++; $display("FAIL mem_only_opnd1 got=%0h exp=9", idex_opnd1); end
        checks++; if (idex_aluop !== 4'd5) begin failures++; $display("FAIL subu_aluop got=%0h exp=5", idex_aluop); end
        // $0 reads as zero even when EX claims to write it
        issue(rtype(5'd0, 5'd2, 5'd3, 5'd0, 6'h2A), 32'h11C);
        fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd0; fwd_ex_wdata = 32'hDEAD;
        reg1_data = 32'h33; reg2_data = 32'h44;
        @(posedge clk); #1;
        checks++; if (idex_opnd1 !== 32'h0) begin failures++; $display("FAIL r0_opnd1 got=%0h exp=0", idex_opnd1); end
        checks++; if (idex_opnd2 !== 32'h44 || idex_aluop !== 4'd6) begin failures++; $display("FAIL slt_dec got=%0h/%0h exp=44/6", idex_opnd2, idex_aluop); end
    endtask

    task automatic test_load_use();
        issue(rtype(5'd4, 5'd0, 5'd5, 5'd0, 6'h25), 32'h120);
        fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd4; fwd_ex_load = 1'b1; fwd_ex_wdata = 32'hBAD;
        #1;
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_ready got=%0h exp=0", id_ready); end
        @(posedge clk); #1;
        checks++; if (idex_valid !== 1'b0 || idex_opnd1 !== 32'h0) begin failures++; $display("FAIL lu_bubble got=%0h/%0h exp=0/0", idex_valid, idex_opnd1); end
        issue(rtype(5'd4, 5'd0, 5'd5, 5'd0, 6'h25), 32'h120);
        fwd_mem_we = 1'b1; fwd_mem_waddr = 5'd4; fwd_mem_wdata = 32'hABCD;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL lu_retry_ready got=%0h exp=1", id_ready); end
        @(posedge clk); #1;
        checks++; if (idex_valid !== 1'b1 || idex_opnd1 !== 32'hABCD) begin failures++; $display("FAIL lu_retry got=%0h/%0h exp=1/abcd", idex_valid, idex_opnd1); end
        checks++; if (idex_aluop !== 4'd1 || idex_waddr !== 5'd5) begin failures++; $display("FAIL lu_retry_dec got=%0h/%0h exp=1/5", idex_aluop, idex_waddr); end
        // SLL ignores rs, so a load to the rs field number is not a hazard
        issue(rtype(5'd4, 5'd7, 5'd6, 5'd2, 6'h00), 32'h124);
        fwd_ex_we = 1'b1; fwd_ex_waddr = 5'd4; fwd_ex_load = 1'b1;
        reg2_data = 32'h80000000;
        #1;
        checks++; if (id_ready !== 1'b1 || reg1_re !== 1'b0) begin failures++; $display("FAIL sll_nohaz got=%0h/%0h exp=1/0", id_ready, reg1_re); end
        @(posedge clk); #1;
        checks++; if (idex_opnd1 !== 32'h80000000 || idex_opnd2 !== 32'd2) begin failures++; $display("FAIL sll_opnds got=%0h/%0h exp=80000000/2", idex_opnd1, idex_opnd2); end
        checks++; if (idex_aluop !== 4'd7 || idex_waddr !== 5'd6) begin failures++; $display("FAIL sll_dec got=%0h/%0h exp=7/6", idex_aluop, idex_waddr); end
    endtask

    task automatic test_mem_ops();
        issue(itype(6'h2B, 5'd1, 5'd3, 16'h0008), 32'h130);
        reg1_data = 32'h1000; reg2_data = 32'h55;
        @(posedge clk); #1;
        checks++; if (idex_opnd1 !== 32'h1000 || idex_opnd2 !== 32'h8) begin failures++; $display("FAIL sw_opnds got=%0h/%0h exp=1000/8", idex_opnd1, idex_opnd2); end
        checks++; if (idex_sdata !== 32'h55 || idex_wreg !== 1'b0 || idex_aluop !== 4'd11) begin failures++; $display("FAIL sw_dec got=%0h/%0h/%0h exp=55/0/b", idex_sdata, idex_wreg, idex_aluop); end
        issue(itype(6'h23, 5'd0, 5'd6, 16'hFFFC), 32'h134);
        @(posedge clk); #1;
        checks++; if (idex_opnd2 !== 32'hFFFFFFFC || idex_aluop !== 4'd10 || idex_wreg !== 1'b1) begin failures++; $display("FAIL lw_dec got=%0h/%0h/%0h exp=fffffffc/a/1", idex_opnd2, idex_aluop, idex_wreg); end
        checks++; if (idex_sdata !== 32'h0) begin failures++; $display("FAIL lw_sdata got=%0h exp=0", idex_sdata); end
        issue(itype(6'h0E, 5'd0, 5'd6, 16'h8000), 32'h138);
        @(posedge clk); #1;
        checks++; if (idex_opnd2 !== 32'h00008000 || idex_aluop !== 4'd3) begin failures++; $display("FAIL xori_zext got=%0h/%0h exp=8000/3", idex_opnd2, idex_aluop); end
    endtask

    task automatic test_stall();
        issue(itype(6'h09, 5'd0, 5'd2, 16'hFFFF), 32'h200);
        @(posedge clk); #1;
        checks++; if (idex_opnd2 !== 32'hFFFFFFFF || idex_aluop !== 4'd4) begin failures++; $display("FAIL addiu_dec got=%0h/%0h exp=ffffffff/4", idex_opnd2, idex_aluop); end
        for (int i = 0; i < 3; i++) begin
            issue(itype(6'h0D, 5'd0, 5'd7, 16'h1111), 32'h204);
            ex_stall = 1'b1;
            #1;
            checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d got=%0h exp=0", i, id_ready); end
            @(posedge clk); #1;
            checks++; if (idex_opnd2 !== 32'hFFFFFFFF || idex_pc !== 32'h200 || idex_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_%0d got=%0h/%0h/%0h exp=ffffffff/200/1", i, idex_opnd2, idex_pc, idex_valid); end
        end
    endtask

    task automatic test_flush();
        issue(itype(6'h0F, 5'd0, 5'd9, 16'h1234), 32'h300);
        @(posedge clk); #1;
        checks++; if (idex_opnd2 !== 32'h12340000 || idex_aluop !== 4'd9 || idex_waddr !== 5'd9) begin failures++; $display("FAIL lui_dec got=%0h/%0h/%0h exp=12340000/9/9", idex_opnd2, idex_aluop, idex_waddr); end
        issue(itype(6'h0D, 5'd0, 5'd7, 16'h1111), 32'h304);
        ex_stall = 1'b1; flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", id_ready); end
        @(posedge clk); #1;
        checks++; if (idex_valid !== 1'b0 || idex_opnd2 !== 32'h0 || idex_pc !== 32'h0) begin failures++; $display("FAIL flush_clear got=%0h/%0h/%0h exp=0/0/0", idex_valid, idex_opnd2, idex_pc); end
    endtask

    task automatic test_back_to_back();
        issue(itype(6'h0C, 5'd0, 5'd8, 16'h00F0), 32'h400);
        @(posedge clk); #1;
        checks++; if (idex_aluop !== 4'd2 || idex_opnd2 !== 32'hF0 || idex_pc !== 32'h400) begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0h exp=2/f0/400", idex_aluop, idex_opnd2, idex_pc); end
        issue(rtype(5'd0, 5'd9, 5'd10, 5'd4, 6'h02), 32'h404);
        reg2_data = 32'hF0F0;
        @(posedge clk); #1;
        checks++; if (idex_aluop !== 4'd8 || idex_opnd1 !== 32'hF0F0 || idex_opnd2 !== 32'd4 || idex_pc !== 32'h404) begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0h/%0h exp=8/f0f0/4/404", idex_aluop, idex_opnd1, idex_opnd2, idex_pc); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++; if (idex_valid !== 1'b0 || idex_aluop !== 4'd0) begin failures++; $display("FAIL idle_bubble got=%0h/%0h exp=0/0", idex_valid, idex_aluop); end
    endtask

    task automatic test_mid_reset_invalid();
        issue(itype(6'h0D, 5'd0, 5'd1, 16'h00AA), 32'h500);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (idex_valid !== 1'b0 || idex_opnd2 !== 32'h0 || idex_pc !== 32'h0 || idex_wreg !== 1'b0) begin failures++; $display("FAIL midrst_clear got=%0h/%0h/%0h/%0h exp=0/0/0/0", idex_valid, idex_opnd2, idex_pc, idex_wreg); end
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%0h exp=0", id_ready); end
        @(negedge clk);
        rst = 1'b1;
        issue(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h504);
        #1;
        checks++; if (id_ready !== 1'b1 || reg1_re !== 1'b0) begin failures++; $display("FAIL inv_ports got=%0h/%0h exp=1/0", id_ready, reg1_re); end
        @(posedge clk); #1;
        checks++; if (idex_valid !== 1'b1 || idex_inv !== 1'b1 || idex_wreg !== 1'b0 || idex_aluop !== 4'd0) begin failures++; $display("FAIL inv_bundle got=%0h/%0h/%0h/%0h exp=1/1/0/0", idex_valid, idex_inv, idex_wreg, idex_aluop); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ori();
        test_forwarding();
        test_load_use();
        test_mem_ops();
        test_stall();
        test_flush();
        test_back_to_back();
        test_mid_reset_invalid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
